// File: rtl/dcache_resp.sv
// dcache_resp: direct-mapped write-through no-write-allocate data cache responder (16B lines, 1-cycle hits)
// Ports: clk/rstn (async active-low); CPU side valid, op, addr, signed_ext, write_type, w_data_CPU -> data_valid, r_data_CPU;
//        memory side mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb <- mem_ready, mem_rvalid, mem_rdata (single outstanding).
module dcache_resp #(
  parameter int SETS           = 256,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        valid,
  input  logic        op,
  input  logic [31:0] addr,
  input  logic        signed_ext,
  input  logic [3:0]  write_type,
  input  logic [31:0] w_data_CPU,
  output logic        data_valid,
  output logic [31:0] r_data_CPU,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WRITE, S_REFILL_REQ, S_REFILL_WAIT, S_RESP} state_t;
  state_t      r_state, w_next;
  logic        r_op, r_sext;
  logic [31:0] r_addr, r_wdata;
  logic [3:0]  r_wt;
  logic [1:0]  r_beat;
  logic [SETS-1:0] r_vld;
  logic [19:0] r_tag  [SETS];
  logic [31:0] r_line [SETS][WORDS_PER_LINE];
  logic [7:0]  w_idx;
  logic [1:0]  w_bank;
  logic        w_hit, w_dv, w_cap, w_last;
  logic [31:0] w_cur, w_merged, w_sh, w_ext;
  assign w_idx  = r_addr[11:4];
  assign w_bank = r_addr[3:2];
  assign w_hit  = r_vld[w_idx] && (r_tag[w_idx] == r_addr[31:12]);
  assign w_cur  = r_line[w_idx][w_bank];
  assign w_last = (r_state == S_REFILL_WAIT) && mem_rvalid && (r_beat == 2'd3);
  // New requests are taken when idle or in the same cycle a response completes.
  assign w_cap  = valid && ((r_state == S_IDLE) || w_dv);
  always_comb begin
    w_dv   = 1'b0;
    w_next = r_state;
    case (r_state)
      S_IDLE:        w_next = valid ? S_LOOKUP : S_IDLE;
      S_LOOKUP:      if (r_op) w_next = S_WRITE;
                     else if (w_hit) w_dv = 1'b1;
                     else w_next = S_REFILL_REQ;
      S_WRITE:       w_dv = mem_ready;
      S_REFILL_REQ:  w_next = mem_ready ? S_REFILL_WAIT : S_REFILL_REQ;
      S_REFILL_WAIT: if (mem_rvalid) w_next = (r_beat == 2'd3) ? S_RESP : S_REFILL_REQ;
      S_RESP:        w_dv = 1'b1;
      default:       w_next = S_IDLE;
    endcase
    if (w_dv) w_next = valid ? S_LOOKUP : S_IDLE;
  end
  always_comb begin
    w_merged = w_cur;
    for (int b = 0; b < 4; b++)
      if (r_wt[b]) w_merged[8*b +: 8] = r_wdata[8*b +: 8];
  end
  // Width comes from the lane mask: single lane = byte, aligned pair = half, else full word.
  assign w_sh  = w_cur >> {r_addr[1:0], 3'b000};
  assign w_ext = (r_wt inside {4'b0001, 4'b0010, 4'b0100, 4'b1000}) ? {{24{r_sext & w_sh[7]}}, w_sh[7:0]} :
                 (r_wt inside {4'b0011, 4'b1100})                  ? {{16{r_sext & w_sh[15]}}, w_sh[15:0]} : w_sh;
  assign data_valid = w_dv;
  assign r_data_CPU = (w_dv && !r_op) ? w_ext : 32'h0;
  assign mem_req    = (r_state == S_WRITE) || (r_state == S_REFILL_REQ);
  assign mem_we     = (r_state == S_WRITE);
  assign mem_addr   = (r_state == S_WRITE)      ? {r_addr[31:2], 2'b00} :
                      (r_state == S_REFILL_REQ) ? {r_addr[31:4], r_beat, 2'b00} : 32'h0;
  assign mem_wdata  = (r_state == S_WRITE) ? r_wdata : 32'h0;
  assign mem_wstrb  = (r_state == S_WRITE) ? r_wt : 4'h0;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_vld   <= '0;
      r_beat  <= 2'd0;
      r_op    <= 1'b0;
      r_sext  <= 1'b0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_wt    <= 4'h0;
    end else begin
      r_state <= w_next;
      if (w_cap) begin
        r_op    <= op;
        r_sext  <= signed_ext;
        r_addr  <= addr;
        r_wdata <= w_data_CPU;
        r_wt    <= write_type;
      end
      if (r_state == S_LOOKUP && !r_op && !w_hit) r_beat <= 2'd0;
      if (r_state == S_REFILL_WAIT && mem_rvalid) r_beat <= r_beat + 2'd1;
      if (w_last) r_vld[w_idx] <= 1'b1;
    end
  end
  // Tag and data storage carry no reset; validity alone gates their use.
  always_ff @(posedge clk) begin
    if (r_state == S_REFILL_WAIT && mem_rvalid) r_line[w_idx][r_beat] <= mem_rdata;
    if (w_last) r_tag[w_idx] <= r_addr[31:12];
    if (r_state == S_LOOKUP && r_op && w_hit) r_line[w_idx][w_bank] <= w_merged;
  end
endmodule

// File: tb/tb_dcache_resp.sv
// tb_dcache_resp: directed self-checking bench for dcache_resp with a simple memory responder
module tb_dcache_resp;
  logic        clk, rstn, valid, op, signed_ext;
  logic [31:0] addr, w_data_CPU;
  logic [3:0]  write_type;
  logic        data_valid, mem_req, mem_we, mem_ready, mem_rvalid;
  logic [31:0] r_data_CPU, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  int tests = 0, fails = 0;
  logic [31:0] mem [logic [31:0]];
  logic [32:0] log_q [$];
  int ready_delay = 0, wait_cnt = 0, wr_cyc_c = 0;
  logic acc_v = 0, acc_we = 0;
  logic [31:0] acc_addr = 0, acc_wd = 0;
  logic [3:0]  acc_st = 0;

  dcache_resp dut (
    .clk(clk), .rstn(rstn), .valid(valid), .op(op), .addr(addr), .signed_ext(signed_ext),
    .write_type(write_type), .w_data_CPU(w_data_CPU), .data_valid(data_valid), .r_data_CPU(r_data_CPU),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata));

  always #5 clk = ~clk;

  // Memory responder: decides ready on the falling edge, returns read data one cycle after acceptance.
  always @(negedge clk) begin
    mem_rvalid = 1'b0;
    if (acc_v) begin
      if (acc_we) begin
        logic [31:0] w;
        w = mem.exists(acc_addr) ? mem[acc_addr] : 32'h0;
        for (int b = 0; b < 4; b++) if (acc_st[b]) w[8*b +: 8] = acc_wd[8*b +: 8];
        mem[acc_addr] = w;
      end else begin
        mem_rvalid = 1'b1;
        mem_rdata  = mem.exists(acc_addr) ? mem[acc_addr] : 32'h0;
      end
      log_q.push_back({acc_we, acc_addr});
      acc_v = 1'b0;
    end
    if (rstn && mem_req) begin
      if (mem_we && mem_wstrb == 4'b1100) wr_cyc_c++;
      mem_ready = (wait_cnt >= ready_delay);
      if (mem_ready) begin
        acc_v = 1'b1; acc_we = mem_we; acc_addr = mem_addr; acc_wd = mem_wdata; acc_st = mem_wstrb;
        wait_cnt = 0;
      end else wait_cnt++;
    end else mem_ready = 1'b0;
  end

  task automatic do_req(input logic o, input logic [31:0] a, input logic s, input logic [3:0] wt,
                        input logic [31:0] wd, output int lat, output logic [31:0] rd);
    valid = 1'b1; op = o; addr = a; signed_ext = s; write_type = wt; w_data_CPU = wd;
    lat = -1; rd = 32'hx;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk); #1;
      if (data_valid) begin lat = c; rd = r_data_CPU; break; end
    end
    valid = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    #1;
    tests++; if (data_valid !== 1'b0) begin fails++; $display("FAIL rst_dv got %b exp 0", data_valid); end
    tests++; if (r_data_CPU !== 32'h0) begin fails++; $display("FAIL rst_rdata got %h exp 0", r_data_CPU); end
    tests++; if ({mem_req, mem_we} !== 2'b00) begin fails++; $display("FAIL rst_req_we got %b exp 00", {mem_req, mem_we}); end
    tests++; if (mem_addr !== 32'h0) begin fails++; $display("FAIL rst_maddr got %h exp 0", mem_addr); end
    tests++; if ({mem_wstrb, mem_wdata} !== 36'h0) begin fails++; $display("FAIL rst_wstrb_wdata got %h exp 0", {mem_wstrb, mem_wdata}); end
    rstn = 1'b1;
    @(negedge clk); #1;
    tests++; if ({data_valid, mem_req} !== 2'b00) begin fails++; $display("FAIL idle_out got %b exp 00", {data_valid, mem_req}); end
  endtask

  task automatic test_read_miss;
    int lat; logic [31:0] rd; logic [32:0] e;
    log_q.delete();
    do_req(1'b0, 32'h1010, 1'b0, 4'b1111, 32'h0, lat, rd);
    tests++; if (lat !== 10) begin fails++; $display("FAIL miss_lat got %0d exp 10", lat); end
    tests++; if (rd !== 32'h0000_00A0) begin fails++; $display("FAIL miss_data got %h exp 000000a0", rd); end
    tests++; if (log_q.size() !== 4) begin fails++; $display("FAIL miss_nreq got %0d exp 4", log_q.size()); end
    for (int i = 0; i < 4; i++) begin
      e = {1'b0, 32'(32'h1010 + 4 * i)};
      tests++; if (log_q[i] !== e) begin fails++; $display("FAIL miss_addr%0d got %h exp %h", i, log_q[i], e); end
    end
    @(negedge clk); #1;
    tests++; if ({data_valid, r_data_CPU} !== 33'h0) begin fails++; $display("FAIL miss_pulse got %h exp 0", {data_valid, r_data_CPU}); end
  endtask

  task automatic test_read_hit;
    int lat; logic [31:0] rd;
    log_q.delete();
    do_req(1'b0, 32'h1010, 1'b0, 4'b1111, 32'h0, lat, rd);
    tests++; if (lat !== 1) begin fails++; $display("FAIL hit_lat got %0d exp 1", lat); end
    tests++; if (rd !== 32'h0000_00A0) begin fails++; $display("FAIL hit_data got %h exp 000000a0", rd); end
    tests++; if (log_q.size() !== 0) begin fails++; $display("FAIL hit_nreq got %0d exp 0", log_q.size()); end
  endtask

  task automatic test_signed;
    int lat; logic [31:0] rd;
    log_q.delete();
    do_req(1'b1, 32'h1013, 1'b0, 4'b1000, 32'h8000_0000, lat, rd);
    tests++; if (lat !== 2 || rd !== 32'h0) begin fails++; $display("FAIL wr_b3 got lat %0d data %h exp 2 0", lat, rd); end
    @(negedge clk); #1;
    tests++; if (log_q.size() !== 1 || log_q[0] !== {1'b1, 32'h1010}) begin fails++; $display("FAIL wr_b3_mem got n %0d %h exp 1 11010", log_q.size(), log_q[0]); end
    do_req(1'b0, 32'h1013, 1'b1, 4'b1000, 32'h0, lat, rd);
    tests++; if (lat !== 1 || rd !== 32'hFFFF_FF80) begin fails++; $display("FAIL lb_s got lat %0d data %h exp 1 ffffff80", lat, rd); end
    do_req(1'b0, 32'h1013, 1'b0, 4'b1000, 32'h0, lat, rd);
    tests++; if (rd !== 32'h0000_0080) begin fails++; $display("FAIL lb_u got %h exp 00000080", rd); end
    do_req(1'b0, 32'h1012, 1'b1, 4'b1100, 32'h0, lat, rd);
    tests++; if (rd !== 32'hFFFF_8000) begin fails++; $display("FAIL lh_s got %h exp ffff8000", rd); end
  endtask

  task automatic test_write_delay;
    int lat; logic [31:0] rd;
    ready_delay = 3; wr_cyc_c = 0; log_q.delete();
    do_req(1'b1, 32'h1012, 1'b0, 4'b1100, 32'hBEEF_0000, lat, rd);
    tests++; if (lat !== 5) begin fails++; $display("FAIL wdel_lat got %0d exp 5", lat); end
    tests++; if (wr_cyc_c !== 4) begin fails++; $display("FAIL wdel_reqcyc got %0d exp 4", wr_cyc_c); end
    ready_delay = 0;
    @(negedge clk); #1;
    tests++; if (log_q.size() !== 1) begin fails++; $display("FAIL wdel_nreq got %0d exp 1", log_q.size()); end
    do_req(1'b0, 32'h1010, 1'b0, 4'b1111, 32'h0, lat, rd);
    tests++; if (lat !== 1 || rd !== 32'hBEEF_00A0) begin fails++; $display("FAIL wdel_read got lat %0d data %h exp 1 beef00a0", lat, rd); end
  endtask

  task automatic test_write_miss;
    int lat; logic [31:0] rd;
    log_q.delete();
    do_req(1'b1, 32'h2000_0000, 1'b0, 4'b1111, 32'h1234_5678, lat, rd);
    @(negedge clk); #1;
    tests++; if (lat !== 2 || log_q.size() !== 1 || log_q[0] !== {1'b1, 32'h2000_0000}) begin fails++; $display("FAIL wmiss got lat %0d n %0d %h exp 2 1 120000000", lat, log_q.size(), log_q[0]); end
    log_q.delete();
    do_req(1'b0, 32'h2000_0000, 1'b0, 4'b1111, 32'h0, lat, rd);
    tests++; if (lat !== 10 || rd !== 32'h1234_5678) begin fails++; $display("FAIL wmiss_read got lat %0d data %h exp 10 12345678", lat, rd); end
    tests++; if (log_q.size() !== 4) begin fails++; $display("FAIL wmiss_refill got %0d exp 4", log_q.size()); end
  endtask

  task automatic test_conflict;
    int lat; logic [31:0] rd;
    do_req(1'b0, 32'h2010, 1'b0, 4'b1111, 32'h0, lat, rd);
    tests++; if (lat !== 10 || rd !== 32'h0000_00C0) begin fails++; $display("FAIL conf_a got lat %0d data %h exp 10 000000c0", lat, rd); end
    do_req(1'b0, 32'h1010, 1'b0, 4'b1111, 32'h0, lat, rd);
    tests++; if (lat !== 10 || rd !== 32'hBEEF_00A0) begin fails++; $display("FAIL conf_b got lat %0d data %h exp 10 beef00a0", lat, rd); end
  endtask

  task automatic test_back_to_back;
    int lat_a = -1, lat_b = -1, dvs = 0;
    logic [31:0] rd_a = 0, rd_b = 0;
    log_q.delete();
    valid = 1'b1; op = 1'b0; addr = 32'h3020; signed_ext = 1'b0; write_type = 4'b1111;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk); #1;
      if (data_valid) begin dvs++; lat_a = c; rd_a = r_data_CPU; break; end
    end
    addr = 32'h1014;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk); #1;
      if (data_valid) begin dvs++; lat_b = c; rd_b = r_data_CPU; break; end
    end
    valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      if (data_valid) dvs++;
    end
    tests++; if (lat_a !== 10 || rd_a !== 32'h0000_00E0) begin fails++; $display("FAIL b2b_a got lat %0d data %h exp 10 000000e0", lat_a, rd_a); end
    tests++; if (lat_b !== 1 || rd_b !== 32'h0000_00A1) begin fails++; $display("FAIL b2b_b got lat %0d data %h exp 1 000000a1", lat_b, rd_b); end
    tests++; if (dvs !== 2 || log_q.size() !== 4) begin fails++; $display("FAIL b2b_once got dv %0d n %0d exp 2 4", dvs, log_q.size()); end
  endtask

  task automatic test_reset_mid_refill;
    int lat; logic [31:0] rd; bit seen = 0, hit = 0;
    valid = 1'b1; op = 1'b0; addr = 32'h4030; signed_ext = 1'b0; write_type = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      if (seen && !mem_req) begin hit = 1; break; end
      if (mem_req) seen = 1;
    end
    tests++; if (!hit) begin fails++; $display("FAIL rmid_wait got 0 exp 1"); end
    rstn = 1'b0; valid = 1'b0;
    #1;
    tests++; if ({data_valid, r_data_CPU, mem_req, mem_we, mem_addr} !== 67'h0) begin fails++; $display("FAIL rmid_out got %h exp 0", {data_valid, r_data_CPU, mem_req, mem_we, mem_addr}); end
    @(negedge clk); #1;
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    log_q.delete();
    do_req(1'b0, 32'h4030, 1'b0, 4'b1111, 32'h0, lat, rd);
    tests++; if (lat !== 10 || rd !== 32'h0000_00F0 || log_q.size() !== 4) begin fails++; $display("FAIL rmid_reread got lat %0d data %h n %0d exp 10 000000f0 4", lat, rd, log_q.size()); end
  endtask

  initial begin
    clk = 0; rstn = 0; valid = 0; op = 0; addr = 0; signed_ext = 0; write_type = 0; w_data_CPU = 0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
    for (int i = 0; i < 4; i++) begin
      mem[32'h1010 + 4 * i] = 32'hA0 + i;
      mem[32'h2010 + 4 * i] = 32'hC0 + i;
      mem[32'h3020 + 4 * i] = 32'hE0 + i;
      mem[32'h4030 + 4 * i] = 32'hF0 + i;
      mem[32'h2000_0000 + 4 * i] = 32'hD0 + i;
    end
    test_reset;
    test_read_miss;
    test_read_hit;
    test_signed;
    test_write_delay;
    test_write_miss;
    test_conflict;
    test_back_to_back;
    test_reset_mid_refill;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
